// File: rtl/dmem_responder.sv
// Word-addressed data memory for the MIPS core's load/store port. Accepts one
// request at a time over valid/ready and answers after LATENCY wait cycles with
// a single-cycle resp_valid pulse. Reset contents hold the two-word sort image.
module dmem_responder #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned LATENCY = 2,
    parameter logic [31:0] INIT0   = 32'h5,
    parameter logic [31:0] INIT1   = 32'h7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // Counter preload; unused when LATENCY is 0 because IDLE goes straight to RESP.
    localparam logic [CntW-1:0] CntLoad = (LATENCY > 0) ? CntW'(LATENCY - 1) : '0;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     mem_q [DEPTH];
    logic [31:0]     rdata_q;
    logic            err_q;

    logic            accept;
    logic            enter_resp;
    logic            acc_we;
    logic [31:0]     acc_addr;
    logic [31:0]     acc_wdata;
    logic [IdxW-1:0] acc_idx;
    logic            acc_err;

    // State register; reset wins over any pending transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    state_d = (LATENCY == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs and the request view used on the RESP-entry edge.
    always_comb begin
        req_ready  = (state_q == StIdle);
        resp_valid = (state_q == StResp);
        accept     = req_ready && req_valid;
        enter_resp = (state_d == StResp) && (state_q != StResp);
        // With zero latency the request enters RESP on its accept edge, before
        // the latches have it, so take it straight from the port.
        acc_we     = accept ? req_we    : we_q;
        acc_addr   = accept ? req_addr  : addr_q;
        acc_wdata  = accept ? req_wdata : wdata_q;
        acc_idx    = acc_addr[IdxW+1:2];
        acc_err    = (acc_addr[1:0] != 2'b00) || (acc_addr[31:IdxW+2] != '0);
    end

    // Request latches, wait counter, memory array and registered response.
    always_ff @(posedge clock) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 0) ? INIT0 : ((i == 1) ? INIT1 : '0);
            end
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt_q   <= CntLoad;
            end else if ((state_q == StWait) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CntW'(1);
            end

            if (enter_resp) begin
                if (acc_err) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end else if (acc_we) begin
                    mem_q[acc_idx] <= acc_wdata;
                    rdata_q        <= '0;
                    err_q          <= 1'b0;
                end else begin
                    rdata_q <= mem_q[acc_idx];
                    err_q   <= 1'b0;
                end
            end
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule
